// File: rtl/tx_dispatch_if.sv
// Request and switch-issue bundle between the decoder front end, tx_dispatch and the receive stage.
// master drives requests and switch occupancy; slave is the dispatcher.
interface tx_dispatch_if #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int A_WIDTH     = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic [7:0]             req_op_id;
    logic [A_WIDTH-1:0]     req_addr;
    logic                   req_wr;
    logic [W_WIDTH-1:0]     req_wr_data;
    logic [NUM_SW_INST-1:0] sw_busy;
    logic [NUM_SW_INST-1:0] sel_en;
    logic [7:0]             op_id;
    logic [A_WIDTH-1:0]     addr_out;
    logic                   wr_out;
    logic [W_WIDTH-1:0]     wr_data_out;

    modport master (
        output req_valid, req_op_id, req_addr, req_wr, req_wr_data, sw_busy,
        input  req_ready, sel_en, op_id, addr_out, wr_out, wr_data_out
    );

    modport slave (
        input  req_valid, req_op_id, req_addr, req_wr, req_wr_data, sw_busy,
        output req_ready, sel_en, op_id, addr_out, wr_out, wr_data_out
    );
endinterface

// File: rtl/tx_dispatch.sv
// Buffers decoder requests and issues each, in order, to the lowest-index idle switch (2-cycle min latency).
// req_ready drops only when the buffer is full; the head waits while every switch is busy.
module tx_dispatch #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int A_WIDTH     = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    tx_dispatch_if.slave                  bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   issued_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]         op_id;
        logic [A_WIDTH-1:0] addr;
        logic               wr;
        logic [W_WIDTH-1:0] wr_data;
    } req_t;

    req_t                   mem [FIFO_DEPTH];
    req_t                   head;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;
    logic [NUM_SW_INST-1:0] free;
    logic [NUM_SW_INST-1:0] pick;

    assign bus.req_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = mem[rd_ptr];

    // sw_busy lags a select by one cycle, so the switch being selected right now is masked too
    assign free = ~bus.sw_busy & ~bus.sel_en;
    assign pick = free & (~free + NUM_SW_INST'(1));
    assign pop  = (fifo_count != '0) && (free != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op_id:   bus.req_op_id,
                             addr:    bus.req_addr,
                             wr:      bus.req_wr,
                             wr_data: bus.req_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            issued_cnt      <= '0;
            bus.sel_en      <= '0;
            bus.op_id       <= '0;
            bus.addr_out    <= '0;
            bus.wr_out      <= 1'b0;
            bus.wr_data_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            bus.sel_en <= pop ? pick : '0;
            // payload holds its last issued value between issues
            if (pop) begin
                bus.op_id       <= head.op_id;
                bus.addr_out    <= head.addr;
                bus.wr_out      <= head.wr;
                bus.wr_data_out <= head.wr_data;
                issued_cnt      <= issued_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tx_dispatch.sv
// Directed and randomized checks of tx_dispatch against a queue-based reference model.
module tb_tx_dispatch;
    localparam int NSW   = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  fifo_count;
    logic [15:0] issued_cnt;
    int          checks = 0;
    int          errors = 0;

    tx_dispatch_if #(.NUM_SW_INST(NSW), .W_WIDTH(8), .A_WIDTH(8)) bus ();

    tx_dispatch #(.NUM_SW_INST(NSW), .W_WIDTH(8), .A_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] a,
                         input logic w, input logic [7:0] d);
        bus.req_valid   = v;
        bus.req_op_id   = op;
        bus.req_addr    = a;
        bus.req_wr      = w;
        bus.req_wr_data = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        bus.sw_busy = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.sel_en !== 5'b0 || bus.op_id !== 8'h0 || bus.addr_out !== 8'h0 ||
            bus.wr_out !== 1'b0 || bus.wr_data_out !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: sel=%b op=%h addr=%h wr=%b data=%h, want all 0",
                     bus.sel_en, bus.op_id, bus.addr_out, bus.wr_out, bus.wr_data_out);
        end
        checks++;
        if (fifo_count !== 3'd0 || issued_cnt !== 16'd0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: count=%0d issued=%0d ready=%b, want 0 0 1",
                     fifo_count, issued_cnt, bus.req_ready);
        end
    endtask

    task automatic test_single_read();
        drive(1'b1, 8'h11, 8'h20, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checks++;
        if (bus.sel_en !== 5'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single_no_bypass: sel=%b count=%0d, want 00000 1", bus.sel_en, fifo_count);
        end
        tick();
        checks++;
        if (bus.sel_en !== 5'b00001 || bus.op_id !== 8'h11 || bus.addr_out !== 8'h20 ||
            bus.wr_out !== 1'b0 || issued_cnt !== 16'd1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_issue: sel=%b op=%h addr=%h wr=%b issued=%0d count=%0d, want 00001 11 20 0 1 0",
                     bus.sel_en, bus.op_id, bus.addr_out, bus.wr_out, issued_cnt, fifo_count);
        end
        tick();
        checks++;
        if (bus.sel_en !== 5'b0 || bus.op_id !== 8'h11) begin
            errors++;
            $display("FAIL single_pulse: sel=%b op=%h, want 00000 11", bus.sel_en, bus.op_id);
        end
    endtask

    task automatic test_back_to_back();
        logic [NSW-1:0] prev_sel;
        logic [NSW-1:0] exp;
        prev_sel    = '0;
        bus.sw_busy = '0;
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(1'b1, 8'(i + 1), 8'(8'h80 + i), 1'b0, 8'h00);
            else       drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
            tick();
            // receive stage registers occupancy: busy follows select one cycle late and stays
            bus.sw_busy = bus.sw_busy | prev_sel;
            prev_sel    = bus.sel_en;
            exp = (i >= 1 && i <= 5) ? NSW'(1) << (i - 1) : '0;
            checks++;
            if (bus.sel_en !== exp || (exp != '0 && bus.op_id !== 8'(i))) begin
                errors++;
                $display("FAIL b2b_cycle%0d: sel=%b op=%h, want %b %h", i, bus.sel_en, bus.op_id, exp, 8'(i));
            end
        end
        bus.sw_busy = '0;
        tick();
    endtask

    task automatic test_all_busy();
        logic [7:0] seen [$];
        do_reset();
        bus.sw_busy = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h21 + i), 8'(8'h40 + i), 1'b0, 8'h00);
            checks++;
            if (bus.req_ready !== (i < 4)) begin
                errors++;
                $display("FAIL busy_ready%0d: ready=%b, want %b", i, bus.req_ready, (i < 4));
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checks++;
        if (fifo_count !== 3'd4 || bus.sel_en !== 5'b0) begin
            errors++;
            $display("FAIL busy_full: count=%0d sel=%b, want 4 00000", fifo_count, bus.sel_en);
        end
        bus.sw_busy = 5'b11011;
        tick();
        checks++;
        if (bus.sel_en !== 5'b00100 || bus.op_id !== 8'h21 || bus.addr_out !== 8'h40) begin
            errors++;
            $display("FAIL busy_release: sel=%b op=%h addr=%h, want 00100 21 40",
                     bus.sel_en, bus.op_id, bus.addr_out);
        end
        bus.sw_busy = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.sel_en != '0) seen.push_back(bus.op_id);
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== 8'h22 || seen[1] !== 8'h23 || seen[2] !== 8'h24) begin
            errors++;
            $display("FAIL busy_drain_order: got %0d issues, want 22 23 24", seen.size());
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.sw_busy = 5'b11111;
        drive(1'b1, 8'h31, 8'h00, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h32, 8'h00, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h33, 8'h00, 1'b0, 8'h00);
        bus.sw_busy = '0;
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checks++;
        if (fifo_count !== 3'd2 || bus.sel_en !== 5'b00001 || bus.op_id !== 8'h31) begin
            errors++;
            $display("FAIL pushpop_count: count=%0d sel=%b op=%h, want 2 00001 31",
                     fifo_count, bus.sel_en, bus.op_id);
        end
        tick();
        checks++;
        if (bus.sel_en !== 5'b00010 || bus.op_id !== 8'h32) begin
            errors++;
            $display("FAIL pushpop_second: sel=%b op=%h, want 00010 32", bus.sel_en, bus.op_id);
        end
        tick();
        checks++;
        if (bus.sel_en !== 5'b00001 || bus.op_id !== 8'h33 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pushpop_third: sel=%b op=%h count=%0d, want 00001 33 0",
                     bus.sel_en, bus.op_id, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.sw_busy = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h41 + i), 8'h55, 1'b1, 8'h66);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        bus.sw_busy = 5'b11110;
        tick();
        checks++;
        if (fifo_count !== 3'd3 || bus.sel_en !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_setup: count=%0d sel=%b, want 3 00001", fifo_count, bus.sel_en);
        end
        bus.sw_busy = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.sel_en !== 5'b0 || bus.op_id !== 8'h0 || bus.addr_out !== 8'h0 || bus.wr_out !== 1'b0 ||
            bus.wr_data_out !== 8'h0 || fifo_count !== 3'd0 || bus.req_ready !== 1'b1 || issued_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_clear: sel=%b op=%h count=%0d ready=%b issued=%0d, want all cleared",
                     bus.sel_en, bus.op_id, fifo_count, bus.req_ready, issued_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.sel_en !== 5'b0 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL midrst_stale%0d: sel=%b count=%0d, want 00000 0", i, bus.sel_en, fifo_count);
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        drive(1'b1, 8'h51, 8'h60, 1'b1, 8'hA5);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++;
        if (bus.sel_en !== 5'b00001 || bus.wr_out !== 1'b1 || bus.wr_data_out !== 8'hA5 ||
            bus.op_id !== 8'h51 || bus.addr_out !== 8'h60) begin
            errors++;
            $display("FAIL write_path: sel=%b wr=%b data=%h op=%h addr=%h, want 00001 1 a5 51 60",
                     bus.sel_en, bus.wr_out, bus.wr_data_out, bus.op_id, bus.addr_out);
        end
    endtask

    task automatic test_random();
        item_t          q [$];
        item_t          cur;
        item_t          last;
        logic [NSW-1:0] m_sel;
        logic [NSW-1:0] free;
        logic [NSW-1:0] exp_sel;
        logic           exp_ready;
        int             exp_issued;
        do_reset();
        last       = '0;
        m_sel      = '0;
        exp_issued = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            cur = item_t'({$urandom, $urandom});
            drive($urandom_range(0, 99) < 60, cur.op, cur.addr, cur.wr, cur.data);
            bus.sw_busy = ((cyc % 120) < 30) ? NSW'(5'b11111) : NSW'($urandom & $urandom);
            exp_ready = (q.size() != DEPTH);
            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready@%0d: ready=%b, want %b", cyc, bus.req_ready, exp_ready);
            end
            // lowest-index switch that is neither busy nor just selected takes the oldest request
            free    = ~bus.sw_busy & ~m_sel;
            exp_sel = '0;
            if (q.size() != 0) begin
                for (int b = 0; b < NSW; b++) begin
                    if (free[b] && exp_sel == '0) exp_sel[b] = 1'b1;
                end
            end
            if (exp_sel != '0) begin
                last       = q.pop_front();
                exp_issued = exp_issued + 1;
            end
            if (bus.req_valid && exp_ready) q.push_back(cur);
            tick();
            m_sel = exp_sel;
            checks++;
            if (bus.sel_en !== exp_sel || bus.op_id !== last.op || bus.addr_out !== last.addr ||
                bus.wr_out !== last.wr || bus.wr_data_out !== last.data) begin
                errors++;
                $display("FAIL rand_issue@%0d: sel=%b op=%h addr=%h wr=%b data=%h, want %b %h %h %b %h",
                         cyc, bus.sel_en, bus.op_id, bus.addr_out, bus.wr_out, bus.wr_data_out,
                         exp_sel, last.op, last.addr, last.wr, last.data);
            end
            checks++;
            if (fifo_count !== 3'(q.size()) || issued_cnt !== 16'(exp_issued)) begin
                errors++;
                $display("FAIL rand_counts@%0d: count=%0d issued=%0d, want %0d %0d",
                         cyc, fifo_count, issued_cnt, q.size(), exp_issued);
            end
        end
    endtask

    initial begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        bus.sw_busy = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_all_busy();
        test_push_pop();
        test_reset_mid();
        test_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_dispatch.md
Name: tx_dispatch

Overview:
- Upstream neighbour of the receive/tracking stage in the unit address decoder.
- Buffers incoming decoder requests in a small FIFO.
- Issues each request to the lowest-index switch instance that is not busy, driving the one-hot select plus the op_id, address and write payload.
- The receive stage latches the op_id on select and reports occupancy back through sw_busy, which this block uses for flow control.

Parameters:
- NUM_SW_INST, 5, number of switch instances (width of sel_en/sw_busy).
- W_WIDTH, 8, data width.
- A_WIDTH, 8, request address width.
- FIFO_DEPTH, 4, request buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request offered.
- req_ready  output  1  request can be accepted (FIFO not full).
- req_op_id  input  8  operation tag.
- req_addr  input  A_WIDTH  target address.
- req_wr  input  1  1 = write, 0 = read.
- req_wr_data  input  W_WIDTH  write data.
- sw_busy  input  NUM_SW_INST  per-switch busy, registered by the downstream stage.
- sel_en  output  NUM_SW_INST  one-hot, single-cycle issue pulse.
- op_id  output  8  tag of the issued request, valid while sel_en != 0.
- addr_out  output  A_WIDTH  address of the issued request.
- wr_out  output  1  write flag of the issued request.
- wr_data_out  output  W_WIDTH  write data of the issued request.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- issued_cnt  output  16  total issues since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst high at a rising edge, any time including mid-operation):
  - FIFO emptied; pointers, fifo_count and issued_cnt = 0.
  - sel_en, op_id, addr_out, wr_out, wr_data_out = 0.
  - req_ready = 1 in the first cycle after reset.
  - In-flight buffered requests are discarded.
- Accept:
  - Push occurs when req_valid && req_ready at a rising edge.
  - req_ready = (fifo_count != FIFO_DEPTH); it is combinational from registered state only and does not depend on req_valid.
- Free mask: free = ~sw_busy & ~sel_en.
  - The sel_en term is required because sw_busy rises one cycle after a select.
  - Without it, the same switch would be issued twice back-to-back.
- Issue decision each cycle:
  - If FIFO not empty and free != 0: pick the lowest set bit of free, pop the FIFO head, and register it.
  - In the next cycle:
    - sel_en = that one-hot bit;
    - op_id, addr_out, wr_out, wr_data_out = head fields;
    - issued_cnt increments.
  - Otherwise sel_en = 0 next cycle, and the payload outputs hold their last values.
- At most one issue per cycle. sel_en is never multi-hot.
- Latency:
  - A request accepted at edge k into an empty FIFO, with a free switch, produces sel_en high in the cycle after edge k+1.
  - Minimum latency is 2 cycles. There is no bypass path.
- Order: strict FIFO order. Requests are never reordered to reach a free switch.
- Simultaneous push and pop:
  - Allowed whenever not full; fifo_count is unchanged.
  - When full, no push occurs in that cycle even if a pop happens (req_ready was low).
- Empty FIFO: no pop and no sel_en, regardless of sw_busy.
- All switches busy: the head waits and the FIFO keeps filling until full, after which req_ready = 0.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty is determined from fifo_count.
- sw_busy is sampled only for the issue decision. Changes on it never alter an already-registered sel_en.

Test Plan:
- Reset then single read: req_op_id=0x11, addr=0x20, sw_busy=0 → sel_en=5'b00001 two cycles after acceptance, op_id=0x11, addr_out=0x20, wr_out=0; issued_cnt=1.
- Back-to-back with sw_busy echoing sel_en one cycle late: 5 requests (ops 0x01..0x05) → sel_en = 00001, 00010, 00100, 01000, 10000 on consecutive cycles, never a repeat.
- All busy: sw_busy=5'b11111, push 5 requests:
  - 4 accepted, fifo_count=4, req_ready=0 on the 5th;
  - drop sw_busy[2] → next issue sel_en=5'b00100 with the first op.
- Simultaneous push and pop at fifo_count=2 → fifo_count stays 2 and order is preserved.
- Assert rst while fifo_count=3 and sel_en active → next cycle all outputs 0, fifo_count=0, req_ready=1, and no stale issue afterwards.
- Write path: req_wr=1, req_wr_data=0xA5 → wr_out=1, wr_data_out=0xA5 coincident with sel_en.
